// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: start bit, LSB-first payload, optional parity, one or two stop bits.
// One bit per baud TICK; TX_OUT, BUSY and FRAME_DONE are registered and follow the state entered on each edge.
module uart_tx_frame_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  FRAME_DONE
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_stop_cnt;
  logic                  r_par_en;
  logic                  r_stop2;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (DATA_VALID) begin
            // Frame options are frozen here so later input changes cannot corrupt the frame.
            r_shift  <= P_DATA;
            r_par_en <= PAR_EN;
            r_stop2  <= STOP2;
            r_parity <= ^P_DATA ^ PAR_TYP;
            r_busy   <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (TICK) begin
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (TICK) begin
            r_tx      <= r_shift[0];
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (TICK) begin
            if (r_bit_cnt == LAST_BIT) begin
              if (r_par_en) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (TICK) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (TICK) begin
            if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_stop_cnt <= 1'b0;
              r_bit_cnt  <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign TX_OUT     = r_tx;
  assign BUSY       = r_busy;
  assign FRAME_DONE = r_done;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: 8-bit and 5-bit instances, table of frames plus reset/rejection sequences.
`timescale 1ns/1ps
module tb_uart_tx_frame_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TICK;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic       sel5;
  logic [7:0] P_DATA;

  logic dv8, dv5;
  logic tx8, busy8, done8;
  logic tx5, busy5, done5;

  int n_cmp = 0;
  int n_err = 0;

  assign dv8 = DATA_VALID & ~sel5;
  assign dv5 = DATA_VALID & sel5;

  always #5 CLK = ~CLK;

  uart_tx_frame_gen #(.DATA_WIDTH(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(P_DATA), .DATA_VALID(dv8),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(tx8), .BUSY(busy8), .FRAME_DONE(done8)
  );

  uart_tx_frame_gen #(.DATA_WIDTH(5)) u_dut5 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(P_DATA[4:0]), .DATA_VALID(dv5),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(tx5), .BUSY(busy5), .FRAME_DONE(done5)
  );

  typedef struct {
    logic       sel5;
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       s2;
    string      bits;   // expected line value per tick, first character first
    int         period; // CLKs per baud tick
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic s5, input logic [7:0] d, input logic pe,
                              input logic pt, input logic s2, input string b, input int p);
    vec_t v;
    v.sel5 = s5; v.data = d; v.pe = pe; v.pt = pt; v.s2 = s2; v.bits = b; v.period = p;
    return v;
  endfunction

  function automatic logic [2:0] obs();
    return sel5 ? {tx5, busy5, done5} : {tx8, busy8, done8};
  endfunction

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: {tx,busy,done} got %b expected %b", nm, act, exp);
    end
  endtask

  // Sends one frame; optional DATA_VALID pulses at cycle rej_c and on the FRAME_DONE edge.
  task automatic run_frame(input int id, input vec_t v, input int rej_c,
                           input bit dv_last, input bit chain);
    int len, nt, last_c;
    logic [2:0] e;
    len    = v.bits.len();
    last_c = (len + 1) * v.period;
    sel5 = v.sel5; P_DATA = v.data; PAR_EN = v.pe; PAR_TYP = v.pt; STOP2 = v.s2;
    DATA_VALID = 1'b1; TICK = 1'b0;
    @(negedge CLK);
    chk($sformatf("f%0d accept", id), obs(), 3'b110);
    DATA_VALID = 1'b0;
    P_DATA = ~v.data; PAR_EN = ~v.pe; PAR_TYP = ~v.pt; STOP2 = ~v.s2;
    for (int c = 1; c <= last_c; c++) begin
      TICK = (c % v.period == 0);
      DATA_VALID = (c == rej_c) || (dv_last && c == last_c);
      if (DATA_VALID) P_DATA = 8'hFF;
      @(negedge CLK);
      nt = c / v.period;
      if (nt == 0)        e = 3'b110;
      else if (nt <= len) e = {v.bits.getc(nt - 1) == "1", 2'b10};
      else                e = 3'b101;
      chk($sformatf("f%0d cyc%0d tick%0d", id, c, nt), obs(), e);
    end
    TICK = 1'b0;
    if (!chain) begin
      DATA_VALID = 1'b0;
      @(negedge CLK);
      chk($sformatf("f%0d idle after done", id), obs(), 3'b100);
    end
  endtask

  initial begin
    vecs[0] = mk(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, "0101001011", 16);
    vecs[1] = mk(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, "01010010101", 16);
    vecs[2] = mk(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, "01010010111", 4);
    vecs[3] = mk(1'b0, 8'h07, 1'b1, 1'b0, 1'b0, "01110000011", 4);
    vecs[4] = mk(1'b0, 8'h07, 1'b1, 1'b1, 1'b0, "01110000001", 4);
    vecs[5] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "00000000011", 16);
    vecs[6] = mk(1'b1, 8'h16, 1'b1, 1'b1, 1'b0, "00110101", 1);
    vecs[7] = mk(1'b1, 8'h0B, 1'b1, 1'b0, 1'b1, "011010111", 2);

    RST = 1'b1; TICK = 1'b0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    STOP2 = 1'b0; P_DATA = 8'h00; sel5 = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset dw8", obs(), 3'b100);
    sel5 = 1'b1;
    chk("reset dw5", obs(), 3'b100);
    sel5 = 1'b0;
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    foreach (vecs[i]) run_frame(i, vecs[i], 0, 1'b0, 1'b0);

    // Busy rejection: DATA_VALID mid-frame and on the FRAME_DONE edge, then one CLK later.
    run_frame(100, mk(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, "0101001011", 4), 15, 1'b1, 1'b1);
    run_frame(101, mk(1'b0, 8'h07, 1'b0, 1'b0, 1'b0, "0111000001", 4), 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the payload.
    sel5 = 1'b0; P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    DATA_VALID = 1'b1; TICK = 1'b0;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      TICK = (c % 4 == 0);
      @(negedge CLK);
    end
    TICK = 1'b0;
    chk("pre-reset in data bit", obs(), 3'b010);
    #2 RST = 1'b1;
    #1 chk("async reset mid-frame", obs(), 3'b100);
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      TICK = (c % 4 == 0);
      @(negedge CLK);
      if (c % 4 == 0) chk($sformatf("idle after reset tick%0d", c / 4), obs(), 3'b100);
    end
    TICK = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_gen.md
Name: uart_tx_frame_gen

Overview:
- Parametrised UART transmit frame generator: serialiser, parity generator and start/stop framing in one block.
- Bit timing comes from an external baud tick.
- Data width, parity enable, parity type and stop-bit count are selectable.
- Drives the serial TX line of the UART TX path directly, and gives the upstream controller a busy/done handshake.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 5..9.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- TICK  input  1  baud tick, one-CLK pulse per bit period; ignored when low
- P_DATA  input  DATA_WIDTH  parallel payload, sampled on acceptance
- DATA_VALID  input  1  request to send P_DATA; accepted only in IDLE
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance
- STOP2  input  1  1 = two stop bits, 0 = one; sampled on acceptance
- TX_OUT  output  1  serial line, registered, idle high
- BUSY  output  1  high from acceptance until frame end, registered
- FRAME_DONE  output  1  one-CLK pulse on return to IDLE, registered

Behaviour:
- Reset (async, immediate) drives:
  - state = IDLE
  - TX_OUT = 1, BUSY = 0, FRAME_DONE = 0
  - bit and stop counters = 0, shift register = 0
- Reset mid-frame aborts the frame; TX_OUT returns high with no partial bits afterwards.
- States: IDLE, WAIT, START, DATA, PARITY, STOP.
- All outputs are registered and reflect the state entered at the same edge.
- IDLE:
  - TX_OUT = 1, BUSY = 0.
  - On an edge with DATA_VALID = 1: capture P_DATA into the shift register; capture PAR_EN, PAR_TYP and STOP2; compute parity = ^P_DATA ^ PAR_TYP.
  - Go to WAIT, BUSY = 1.
  - TICK is irrelevant for acceptance.
- WAIT: TX_OUT = 1. On TICK go to START, TX_OUT = 0. This aligns the start bit to a full tick period.
- START: on TICK go to DATA, TX_OUT = shift[0], bit counter = 0.
- DATA (LSB first):
  - On TICK: if bit counter == DATA_WIDTH-1, go to PARITY (TX_OUT = parity) when latched PAR_EN = 1, else go to STOP (TX_OUT = 1).
  - Otherwise shift right, TX_OUT = next bit, increment the counter.
- PARITY: on TICK go to STOP, TX_OUT = 1.
- STOP:
  - On TICK with latched STOP2 = 1 and stop counter = 0: stay in STOP, stop counter = 1.
  - Otherwise go to IDLE: BUSY = 0, FRAME_DONE = 1 for exactly one cycle, counters cleared.
- Every bit lasts exactly one tick interval.
- Frame length in ticks, WAIT excluded: 1 + DATA_WIDTH + PAR_EN + 1 + STOP2.
- DATA_VALID while BUSY = 1 is ignored, with no queuing.
- DATA_VALID on the same edge that returns STOP to IDLE is ignored. The earliest new acceptance is the next edge, so back-to-back frames insert at least the WAIT state.
- Changes to P_DATA, PAR_EN, PAR_TYP or STOP2 after acceptance do not affect the current frame.
- TICK while in IDLE has no effect.
- TICK held high continuously is legal: one bit per CLK.
- Parity is computed over exactly DATA_WIDTH bits.
- Bit counter width is $clog2(DATA_WIDTH).

Test Plan:
- Reset check: assert RST mid-DATA with no clock edge → TX_OUT = 1, BUSY = 0 immediately. After release, idle stays high for 20 ticks.
- 8N1, P_DATA = 8'hA5, PAR_EN = 0, STOP2 = 0, TICK every 16 CLK:
  - Line sequence per tick is 0,1,0,1,0,0,1,0,1,1.
  - BUSY spans WAIT + 10 ticks.
  - FRAME_DONE pulses once, 1 CLK wide.
- 8E1 and 8O1 with P_DATA = 8'hA5:
  - Parity bit 0 (even) and 1 (odd), after the 8 data bits.
  - Repeat with 8'h07: parity 1 (even) and 0 (odd).
- 8N2 with P_DATA = 8'h00: line sequence 0, 0×8, 1, 1, for 11 ticks total.
- Busy rejection: second DATA_VALID with P_DATA = 8'hFF mid-frame, and another on the FRAME_DONE edge → only the first frame is transmitted. A DATA_VALID one CLK later starts a new frame.
- DATA_WIDTH = 5, PAR_EN = 1, PAR_TYP = 1, P_DATA = 5'b10110:
  - Line sequence 0,0,1,1,0,1, parity 0, then 1.
  - TICK held high: each bit lasts exactly 1 CLK.
